// File: rtl/inst_axi_bridge_if.sv
// Signal bundle between the IF-stage fetch port, the bridge and the AXI read channel.
// The master modport is the bridge's view; the slave modport is the environment (IF stage plus AXI slave).
interface inst_axi_bridge_if;
  logic        inst_sram_en;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        flush;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_en, inst_sram_wr, inst_sram_size, inst_sram_addr, flush,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    output inst_sram_en, inst_sram_wr, inst_sram_size, inst_sram_addr, flush,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the sram-like instruction fetch port to a single-beat AXI read channel.
// One transaction in flight; a flush cancels the response of the in-flight request.
module inst_axi_bridge #(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] RST_DATA = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  inst_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        cancel_q, cancel_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cancel_d  = cancel_q;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        // A flush arriving with the accept redirects to this request, so it is never cancelled here.
        cancel_d = 1'b0;
        if (bus.inst_sram_en && !bus.inst_sram_wr) begin
          addr_d  = bus.inst_sram_addr;
          size_d  = bus.inst_sram_size;
          state_d = AR;
        end
      end
      AR: begin
        if (bus.flush) cancel_d = 1'b1;
        if (bus.arready) state_d = R;
      end
      R: begin
        if (bus.flush) cancel_d = 1'b1;
        if (bus.rvalid) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          if (!cancel_q && !bus.flush) begin
            data_ok_d = 1'b1;
            rdata_d   = bus.rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      size_q    <= 2'b00;
      cancel_q  <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= RST_DATA;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cancel_q  <= cancel_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // addr_ok comes purely from state so IF can derive en from it without a loop.
  assign bus.inst_sram_addr_ok = (state_q == IDLE);
  assign bus.inst_sram_data_ok = data_ok_q;
  assign bus.inst_sram_rdata   = rdata_q;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arvalid = (state_q == AR);
  assign bus.rready  = (state_q == R);

  logic unused_ok;
  assign unused_ok = ^{bus.rresp, bus.rlast};

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: the initial block plays IF stage and AXI slave,
// a negedge monitor pops expected words from a scoreboard whenever data_ok pulses.
module tb_inst_axi_bridge;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] sb_q[$];
  logic [31:0] last_data;

  inst_axi_bridge_if bus ();

  inst_axi_bridge #(
    .AXI_ID  (4'd0),
    .RST_DATA(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every data_ok must match the oldest expected word.
  always @(negedge clk) begin
    if (bus.inst_sram_data_ok === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_data_ok", 32'd1, 32'd0);
      end else begin
        check("sb_rdata", bus.inst_sram_rdata, sb_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic do_flush);
    check("issue_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = addr;
    bus.flush          = do_flush;
    step();
    bus.inst_sram_en = 1'b0;
    bus.flush        = 1'b0;
    check("ar_arvalid", {31'd0, bus.arvalid}, 32'd1);
    check("ar_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    check("ar_araddr", bus.araddr, addr);
    check("ar_fields", {bus.arid, bus.arlen, bus.arsize, bus.arburst},
          {4'd0, 8'd0, 3'b010, 2'b01});
  endtask

  task automatic ar_handshake(input logic [31:0] addr, input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      check("stall_arvalid", {31'd0, bus.arvalid}, 32'd1);
      check("stall_araddr", bus.araddr, addr);
      check("stall_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    end
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    check("r_rready", {31'd0, bus.rready}, 32'd1);
    check("r_arvalid", {31'd0, bus.arvalid}, 32'd0);
  endtask

  task automatic r_beat(input logic [31:0] data, input logic deliver, input logic do_flush);
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.flush  = do_flush;
    if (deliver) sb_q.push_back(data);
    step();
    bus.rvalid = 1'b0;
    bus.flush  = 1'b0;
    check("beat_data_ok", {31'd0, bus.inst_sram_data_ok}, {31'd0, deliver});
    check("beat_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    if (deliver) last_data = data;
    check("beat_rdata_hold", bus.inst_sram_rdata, last_data);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    last_data = 32'h0;
    reset     = 1'b1;
    bus.inst_sram_en   = 1'b0;
    bus.inst_sram_wr   = 1'b0;
    bus.inst_sram_size = 2'b10;
    bus.inst_sram_addr = 32'h0;
    bus.flush   = 1'b0;
    bus.arready = 1'b0;
    bus.rdata   = 32'h0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b1;
    bus.rvalid  = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("rst_rready", {31'd0, bus.rready}, 32'd0);
    check("rst_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    check("rst_rdata", bus.inst_sram_rdata, 32'h0);

    $display("[TB] minimum latency fetch");
    issue(32'hbfc00000, 1'b0);
    ar_handshake(32'hbfc00000, 0);
    r_beat(32'h3c1dbfc0, 1'b1, 1'b0);
    step();
    check("pulse_len", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    check("rdata_hold", bus.inst_sram_rdata, 32'h3c1dbfc0);

    $display("[TB] write request ignored");
    bus.inst_sram_en = 1'b1;
    bus.inst_sram_wr = 1'b1;
    bus.inst_sram_addr = 32'h00001000;
    step();
    bus.inst_sram_en = 1'b0;
    bus.inst_sram_wr = 1'b0;
    check("wr_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("wr_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);

    $display("[TB] arready stalled five cycles");
    issue(32'hbfc00010, 1'b0);
    ar_handshake(32'hbfc00010, 5);
    r_beat(32'h24080001, 1'b1, 1'b0);

    $display("[TB] flush during AR then redirect");
    issue(32'hbfc00004, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    ar_handshake(32'hbfc00004, 1);
    r_beat(32'hdeadbeef, 1'b0, 1'b0);
    issue(32'hbfc00380, 1'b0);
    ar_handshake(32'hbfc00380, 0);
    r_beat(32'h401a6800, 1'b1, 1'b0);

    $display("[TB] flush in R before the beat");
    issue(32'hbfc00020, 1'b0);
    ar_handshake(32'hbfc00020, 0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    r_beat(32'h11111111, 1'b0, 1'b0);

    $display("[TB] flush coincident with beat");
    issue(32'hbfc00024, 1'b0);
    ar_handshake(32'hbfc00024, 0);
    r_beat(32'h22222222, 1'b0, 1'b1);

    $display("[TB] flush coincident with accept");
    issue(32'hbfc00380, 1'b1);
    ar_handshake(32'hbfc00380, 2);
    r_beat(32'h33333333, 1'b1, 1'b0);

    $display("[TB] back-to-back fetch after delivery");
    issue(32'hbfc00384, 1'b0);
    ar_handshake(32'hbfc00384, 0);
    r_beat(32'h44444444, 1'b1, 1'b0);

    $display("[TB] reset while in R");
    issue(32'hbfc00028, 1'b0);
    ar_handshake(32'hbfc00028, 0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h55555555;
    reset      = 1'b1;
    step();
    reset      = 1'b0;
    bus.rvalid = 1'b0;
    check("mid_rst_addr_ok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    check("mid_rst_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    check("mid_rst_rready", {31'd0, bus.rready}, 32'd0);
    check("mid_rst_rdata", bus.inst_sram_rdata, 32'h0);
    step();
    check("post_rst_data_ok", {31'd0, bus.inst_sram_data_ok}, 32'd0);

    step();
    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
